// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path.
//   fetch_state_e : fetch sequencer FSM states (issue reads, capture last byte, hold word)
//   INST_BYTES    : bytes per instruction word
//   CNT_W         : width of the byte counter
//   PC_STEP       : program counter increment per word
package fetch_pkg;

    typedef enum logic [1:0] {
        StIssue = 2'd0,
        StLast  = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned CNT_W      = $clog2(INST_BYTES);
    localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/byte_assembler.sv
// 32-bit shift-left-by-8 assembly register. The incoming byte enters at bit 0, so bytes
// fed in address order end up big-endian (first byte in [31:24]).
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clear_i    : clear the register (wins over shift_en_i)
//   shift_en_i : shift byte_i in
//   byte_i     : incoming byte
//   word_o     : current register contents
module byte_assembler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [31:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (clear_i) begin
            word_d = 32'd0;
        end else if (shift_en_i) begin
            word_d = {word_q[23:0], byte_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= 32'd0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads four bytes from a byte-wide instruction memory (one per
// cycle, data one cycle after the read), assembles a big-endian 32-bit word and presents it to
// decode with a valid/ready handshake. Owns the PC and accepts branch redirects from decode.
//   clk, rst                     : clock, synchronous active-high reset
//   redirect_valid, redirect_pc  : PC change request from decode (highest priority after reset)
//   mem_rd_en, mem_addr          : byte read request to instruction memory
//   mem_rdata                    : byte returned for the previous cycle's read
//   inst_valid, inst_ready       : word handshake to decode
//   inst, inst_pc, next_pc       : assembled word, its address, and address + 4
//   busy                         : fetch in progress (not holding a word)
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 11,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic [31:0]       next_pc,
    output logic              busy
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_pending_q, rd_pending_d;
    logic             inst_valid_q, inst_valid_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic [31:0]      next_pc_q, next_pc_d;

    logic             asm_clear;
    logic [31:0]      asm_word;
    logic             handshake;

    assign mem_rd_en = (state_q == StIssue);
    // Byte address wraps silently inside the memory window.
    assign mem_addr  = pc_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
    assign handshake = inst_valid_q & inst_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        next_pc_d    = next_pc_q;
        asm_clear    = 1'b0;
        // A read issued in the redirect cycle belongs to the old stream; drop its data.
        rd_pending_d = mem_rd_en & ~redirect_valid;

        if (redirect_valid) begin
            // A coincident handshake still consumes the word; either way valid drops.
            pc_d         = redirect_pc;
            cnt_d        = '0;
            state_d      = StIssue;
            asm_clear    = 1'b1;
            inst_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIssue: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(INST_BYTES - 1)) begin
                        state_d = StLast;
                    end
                end
                StLast: begin
                    // Fourth byte arrives now; merge it without waiting for the shift.
                    inst_d       = (asm_word << 8) | {24'd0, mem_rdata};
                    inst_pc_d    = pc_q;
                    next_pc_d    = pc_q + PC_STEP;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + PC_STEP;
                    asm_clear    = 1'b1;
                    state_d      = StHold;
                end
                StHold: begin
                    if (handshake) begin
                        inst_valid_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = StIssue;
                    end
                end
                default: begin
                    state_d = StIssue;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIssue;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            next_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            next_pc_q    <= next_pc_d;
        end
    end

    byte_assembler u_byte_assembler (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (asm_clear),
        .shift_en_i (rd_pending_q),
        .byte_i     (mem_rdata),
        .word_o     (asm_word)
    );

    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign next_pc    = next_pc_q;
    assign busy       = (state_q != StHold);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Memory holds byte (addr + 1) & 0xFF at every address.
module tb_fetch_sequencer;

    localparam int unsigned ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic [31:0]       next_pc;
    logic              busy;

    logic [7:0] mem [0:2047];
    int n_cmp  = 0;
    int n_fail = 0;
    int hs_cnt = 0;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'd0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .next_pc        (next_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // One-cycle read latency memory model.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    always @(negedge clk) if (!rst && inst_valid && inst_ready) hs_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts in an issue cycle with cnt=0 at pc; ends in the cycle the word is presented.
    task automatic fetch_word(input logic [31:0] pc, input logic [31:0] word);
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = (pc + 32'(i)) & 32'h7FF;
            chk("mem_addr", {21'd0, mem_addr}, a);
            chk("mem_rd_en", {31'd0, mem_rd_en}, 32'd1);
            chk("valid_during_fetch", {31'd0, inst_valid}, 32'd0);
            step();
        end
        chk("last_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("last_busy", {31'd0, busy}, 32'd1);
        step();
        chk("inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("inst", inst, word);
        chk("inst_pc", inst_pc, pc);
        chk("next_pc", next_pc, pc + 32'd4);
        chk("hold_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int hs_before;
        for (int i = 0; i < 2048; i++) mem[i] = 8'((i + 1) & 255);

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_ready     = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state (first cycle after release).
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        // First word, then stall for 10 cycles.
        fetch_word(32'd0, 32'h01020304);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst", inst, 32'h01020304);
            chk("stall_inst_pc", inst_pc, 32'd0);
            chk("stall_rd_en", {31'd0, mem_rd_en}, 32'd0);
            chk("stall_busy", {31'd0, busy}, 32'd0);
        end
        inst_ready = 1'b1;
        step();
        fetch_word(32'd4, 32'h05060708);
        step();

        // Redirect while cnt==2 at pc 8.
        step();
        step();
        chk("pre_redirect_addr", {21'd0, mem_addr}, 32'h00A);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        fetch_word(32'h40, 32'h41424344);

        // Redirect coincident with handshake.
        hs_before      = hs_cnt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("hs_redirect_count", 32'(hs_cnt), 32'(hs_before + 1));
        fetch_word(32'h100, 32'h01020304);

        // Redirect in hold while stalled: the held word is dropped.
        inst_ready     = 1'b0;
        hs_before      = hs_cnt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7FE;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        chk("drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("drop_hs_count", 32'(hs_cnt), 32'(hs_before));
        // Address window wrap.
        fetch_word(32'h7FE, 32'hFF000102);
        step();
        chk("after_wrap_addr", {21'd0, mem_addr}, 32'h002);

        // Back-to-back redirects: last one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        chk("b2b_first_addr", {21'd0, mem_addr}, 32'h200);
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        // PC wraps at 2^32: next_pc == 0.
        fetch_word(32'hFFFF_FFFC, 32'hFDFEFF00);
        step();
        chk("pc_wrap_addr", {21'd0, mem_addr}, 32'h000);

        // Reset mid-fetch dominates a coincident redirect.
        step();
        chk("pre_reset_addr", {21'd0, mem_addr}, 32'h001);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        fetch_word(32'd0, 32'h01020304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
